id_ex_stage: RTL

ID/EX pipeline register plus execute-side operand preparation for the 5-stage MIPS core. Latches decoded fields from ID each cycle (with stall and flush), resolves RAW hazards by forwarding from EX/MEM and MEM/WB, and translates the main-decoder ALU class and funct into the 4-bit ALU control code. Sits between the decoder and the ALU, driving the ALU's `data_a`, `data_b` and `operation` inputs directly.

---
 rtl/id_ex_stage.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//
// ID/EX pipeline register and execute-side operand preparation for the
// 5-stage MIPS core.
//
// The block latches the decoded ID fields on each rising clock edge:
//   - flush loads a bubble (all fields 0) and takes priority over stall.
//   - stall holds the latched fields.
//   - otherwise every id_* input is captured.
//
// From the latched state it then computes, purely combinationally:
//   - forwarded rs/rt values, taken from EX/MEM first, then MEM/WB, then
//     the latched register value;
//   - the ALU operands;
//   - the 4-bit ALU control code.
//
// Handshake: the block has no valid/ready pair. Every cycle is a transfer
// unless stall is high (hold) or flush is high (bubble). The ALU-facing
// outputs are valid one cycle after an ID capture.
//
// Ports
//   clk, reset             clock, asynchronous active-high reset
//   stall, flush           pipeline hold / bubble insert
//   id_*                   decoded fields and control from ID
//   exm_rd/_reg_write/_result  EX/MEM forwarding source
//   wb_rd/_reg_write/_result   MEM/WB forwarding source
//   alu_data_a/_b          ALU operands
//   alu_operation          ALU control code
//   ex_store_data          forwarded rt value, used as store data
//   ex_write_reg           destination register (reg_dst ? rd : rt)
//   ex_rs, ex_rt           latched source addresses for the hazard unit
//   ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  latched control
// -----------------------------------------------------------------------------
module id_ex_stage #(
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          stall,
   input  logic          flush,
   input  logic [DW-1:0] id_rs_data,
   input  logic [DW-1:0] id_rt_data,
   input  logic [DW-1:0] id_imm,
   input  logic [4:0]    id_rs,
   input  logic [4:0]    id_rt,
   input  logic [4:0]    id_rd,
   input  logic [4:0]    id_shamt,
   input  logic [5:0]    id_funct,
   input  logic [2:0]    id_alu_op,
   input  logic          id_alu_src,
   input  logic          id_reg_dst,
   input  logic          id_reg_write,
   input  logic          id_mem_read,
   input  logic          id_mem_write,
   input  logic          id_mem_to_reg,
   input  logic [4:0]    exm_rd,
   input  logic          exm_reg_write,
   input  logic [DW-1:0] exm_result,
   input  logic [4:0]    wb_rd,
   input  logic          wb_reg_write,
   input  logic [DW-1:0] wb_result,
   output logic [DW-1:0] alu_data_a,
   output logic [DW-1:0] alu_data_b,
   output logic [3:0]    alu_operation,
   output logic [DW-1:0] ex_store_data,
   output logic [4:0]    ex_write_reg,
   output logic [4:0]    ex_rs,
   output logic [4:0]    ex_rt,
   output logic          ex_reg_write,
   output logic          ex_mem_read,
   output logic          ex_mem_write,
   output logic          ex_mem_to_reg
);

   // Latched ID/EX fields
   logic [DW-1:0] r_rs_data;
   logic [DW-1:0] r_rt_data;
   logic [DW-1:0] r_imm;
   logic [4:0]    r_rs;
   logic [4:0]    r_rt;
   logic [4:0]    r_rd;
   logic [4:0]    r_shamt;
   logic [5:0]    r_funct;
   logic [2:0]    r_alu_op;
   logic          r_alu_src;
   logic          r_reg_dst;
   logic          r_reg_write;
   logic          r_mem_read;
   logic          r_mem_write;
   logic          r_mem_to_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rs_data    <= '0;
         r_rt_data    <= '0;
         r_imm        <= '0;
         r_rs         <= '0;
         r_rt         <= '0;
         r_rd         <= '0;
         r_shamt      <= '0;
         r_funct      <= '0;
         r_alu_op     <= '0;
         r_alu_src    <= 1'b0;
         r_reg_dst    <= 1'b0;
         r_reg_write  <= 1'b0;
         r_mem_read   <= 1'b0;
         r_mem_write  <= 1'b0;
         r_mem_to_reg <= 1'b0;
      end else if (flush) begin
         // Bubble: the all-zero state decodes as an ADD of 0 and 0 that
         // writes nothing.
         r_rs_data    <= '0;
         r_rt_data    <= '0;
         r_imm        <= '0;
         r_rs         <= '0;
         r_rt         <= '0;
         r_rd         <= '0;
         r_shamt      <= '0;
         r_funct      <= '0;
         r_alu_op     <= '0;
         r_alu_src    <= 1'b0;
         r_reg_dst    <= 1'b0;
         r_reg_write  <= 1'b0;
         r_mem_read   <= 1'b0;
         r_mem_write  <= 1'b0;
         r_mem_to_reg <= 1'b0;
      end else if (!stall) begin
         r_rs_data    <= id_rs_data;
         r_rt_data    <= id_rt_data;
         r_imm        <= id_imm;
         r_rs         <= id_rs;
         r_rt         <= id_rt;
         r_rd         <= id_rd;
         r_shamt      <= id_shamt;
         r_funct      <= id_funct;
         r_alu_op     <= id_alu_op;
         r_alu_src    <= id_alu_src;
         r_reg_dst    <= id_reg_dst;
         r_reg_write  <= id_reg_write;
         r_mem_read   <= id_mem_read;
         r_mem_write  <= id_mem_write;
         r_mem_to_reg <= id_mem_to_reg;
      end
   end

   // Forwarding. EX/MEM holds the younger result, so it wins over MEM/WB.
   // $0 is never forwarded, even when a stage claims to write it.
   logic [DW-1:0] fwd_a;
   logic [DW-1:0] fwd_b;

   always_comb begin
      fwd_a = r_rs_data;
      if (exm_reg_write && (exm_rd != 5'd0) && (exm_rd == r_rs))
         fwd_a = exm_result;
      else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == r_rs))
         fwd_a = wb_result;
   end

   always_comb begin
      fwd_b = r_rt_data;
      if (exm_reg_write && (exm_rd != 5'd0) && (exm_rd == r_rt))
         fwd_b = exm_result;
      else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == r_rt))
         fwd_b = wb_result;
   end

   // Immediate shifts (sll/srl/sra) carry the shift amount in shamt and
   // route it onto operand A. Variable shifts already have it in rs.
   logic shift_imm;

   always_comb begin
      shift_imm = (r_alu_op == 3'b010) &&
                  ((r_funct == 6'b000000) ||
                   (r_funct == 6'b000010) ||
                   (r_funct == 6'b000011));
   end

   // ALU control decode
   logic [3:0] op_code;

   always_comb begin
      op_code = 4'b1111;
      case (r_alu_op)
         3'b000: op_code = 4'b0010;
         3'b001: op_code = 4'b0110;
         3'b011: op_code = 4'b0000;
         3'b100: op_code = 4'b0001;
         3'b101: op_code = 4'b1101;
         3'b110: op_code = 4'b0111;
         3'b111: op_code = 4'b1001;
         3'b010: begin
            case (r_funct)
               6'b100000: op_code = 4'b0010;
               6'b100001: op_code = 4'b0011;
               6'b100010: op_code = 4'b0110;
               6'b100011: op_code = 4'b0100;
               6'b100100: op_code = 4'b0000;
               6'b100101: op_code = 4'b0001;
               6'b100110: op_code = 4'b1101;
               6'b100111: op_code = 4'b1100;
               6'b101010: op_code = 4'b0111;
               6'b101011: op_code = 4'b1001;
               6'b000000,
               6'b000100: op_code = 4'b1000;
               6'b000010,
               6'b000110: op_code = 4'b1010;
               6'b000011,
               6'b000111: op_code = 4'b1011;
               // Unused code; the ALU returns zero for it.
               default:   op_code = 4'b1111;
            endcase
         end
         default: op_code = 4'b1111;
      endcase
   end

   assign alu_data_a    = shift_imm ? {{(DW-5){1'b0}}, r_shamt} : fwd_a;
   assign alu_data_b    = r_alu_src ? r_imm : fwd_b;
   assign alu_operation = op_code;
   assign ex_store_data = fwd_b;
   assign ex_write_reg  = r_reg_dst ? r_rd : r_rt;
   assign ex_rs         = r_rs;
   assign ex_rt         = r_rt;
   assign ex_reg_write  = r_reg_write;
   assign ex_mem_read   = r_mem_read;
   assign ex_mem_write  = r_mem_write;
   assign ex_mem_to_reg = r_mem_to_reg;

endmodule
